// File: rtl/mux_2x1_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared 2:1 mux arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface mux_2x1_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_0_in;
    logic              req_1_in;
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic              grant_0;
    logic              grant_1;
    logic              Select_out;
    logic [DATA_W-1:0] Y_out;
    logic              Y_valid;
    logic              busy_out;

    modport master (
        output req_0_in, req_1_in, A_in, B_in,
        input  grant_0, grant_1, Select_out, Y_out, Y_valid, busy_out
    );

    modport slave (
        input  req_0_in, req_1_in, A_in, B_in,
        output grant_0, grant_1, Select_out, Y_out, Y_valid, busy_out
    );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// Round-robin owner of a registered 2:1 mux. Each ownership is capped at
// MAX_BURST grant cycles, and Y_out captures the owner's data while its request holds.
//
// state   | meaning
// IDLE    | no owner, mux select holds its last value
// GRANT_0 | requester 0 owns the mux (A_in selected)
// GRANT_1 | requester 1 owns the mux (B_in selected)
module mux_2x1_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic           clk,
    input logic           reset,
    mux_2x1_arbiter_if.slave bus
);
    localparam int              CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_0 = 2'd1,
        GRANT_1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_cnt_nxt;
    logic              sel;
    logic              sel_nxt;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] y_nxt;
    logic              y_valid;
    logic              y_valid_nxt;
    logic [DATA_W-1:0] mux_data;

    logic owner;
    logic req_own;
    logic req_other;
    logic burst_end;

    // The datapath mux is steered by the registered select, which tracks the owner.
    assign mux_data = sel ? bus.B_in : bus.A_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            sel        <= 1'b0;
            y          <= '0;
            y_valid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            sel        <= sel_nxt;
            y          <= y_nxt;
            y_valid    <= y_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        sel_nxt        = sel;
        y_nxt          = y;
        y_valid_nxt    = 1'b0;
        owner          = (state == GRANT_1);
        req_own        = owner ? bus.req_1_in : bus.req_0_in;
        req_other      = owner ? bus.req_0_in : bus.req_1_in;
        burst_end      = !req_own || (beat_cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (bus.req_0_in && bus.req_1_in) begin
                    state_nxt = last_grant ? GRANT_0 : GRANT_1;
                end else if (bus.req_0_in) begin
                    state_nxt = GRANT_0;
                end else if (bus.req_1_in) begin
                    state_nxt = GRANT_1;
                end
            end
            GRANT_0, GRANT_1: begin
                // A grant cycle only yields a beat if the owner still asks at this edge.
                if (req_own) begin
                    y_nxt       = mux_data;
                    y_valid_nxt = 1'b1;
                end
                if (burst_end) begin
                    last_grant_nxt = owner;
                    beat_cnt_nxt   = '0;
                    if (req_other) begin
                        state_nxt = owner ? GRANT_0 : GRANT_1;
                    end else if (req_own) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    beat_cnt_nxt = beat_cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == GRANT_1) begin
            sel_nxt = 1'b1;
        end else if (state_nxt == GRANT_0) begin
            sel_nxt = 1'b0;
        end
    end

    assign bus.grant_0    = (state == GRANT_0);
    assign bus.grant_1    = (state == GRANT_1);
    assign bus.busy_out   = (state != IDLE);
    assign bus.Select_out = sel;
    assign bus.Y_out      = y;
    assign bus.Y_valid    = y_valid;
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Bench for the round-robin mux arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance
// share stimulus and are compared each cycle against an ownership/burst model.
module tb_mux_2x1_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    mux_2x1_arbiter_if #(.DATA_W(8)) bus0 ();
    mux_2x1_arbiter_if #(.DATA_W(8)) bus1 ();

    mux_2x1_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mux_2x1_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner is -1 (nobody), 0 or 1; used counts grant cycles in the current burst.
    int         maxb [2] = '{4, 1};
    int         own  [2] = '{-1, -1};
    int         last [2] = '{1, 1};
    int         used [2] = '{0, 0};
    logic       msel [2] = '{1'b0, 1'b0};
    logic [7:0] my   [2] = '{8'h00, 8'h00};
    logic       myv  [2] = '{1'b0, 1'b0};

    task automatic model_step(input int k);
        logic r0, r1, mine, other;
        int   x;
        r0 = bus0.req_0_in;
        r1 = bus0.req_1_in;
        if (own[k] < 0) begin
            myv[k] = 1'b0;
            if (r0 && r1)  own[k] = 1 - last[k];
            else if (r0)   own[k] = 0;
            else if (r1)   own[k] = 1;
        end else begin
            x     = own[k];
            mine  = (x == 0) ? r0 : r1;
            other = (x == 0) ? r1 : r0;
            if (mine) begin
                my[k]  = (x == 0) ? bus0.A_in : bus0.B_in;
                myv[k] = 1'b1;
            end else begin
                myv[k] = 1'b0;
            end
            used[k] = used[k] + 1;
            if (!mine || used[k] == maxb[k]) begin
                last[k] = x;
                used[k] = 0;
                if (other)     own[k] = 1 - x;
                else if (mine) own[k] = x;
                else           own[k] = -1;
            end
        end
        if (own[k] >= 0) msel[k] = (own[k] == 1);
    endtask

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                own[k] = -1; last[k] = 1; used[k] = 0;
                msel[k] = 1'b0; my[k] = 8'h00; myv[k] = 1'b0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic cmp_out(input int k, input logic g0, input logic g1, input logic s,
                           input logic [7:0] y, input logic yv, input logic busy);
        logic e_g0, e_g1, e_busy;
        e_g0   = (own[k] == 0);
        e_g1   = (own[k] == 1);
        e_busy = (own[k] >= 0);
        n_chk++;
        if (g0 !== e_g0 || g1 !== e_g1 || s !== msel[k] || y !== my[k] ||
            yv !== myv[k] || busy !== e_busy) begin
            n_fail++;
            $display("FAIL model_cmp dut%0d t=%0t got g0=%b g1=%b sel=%b y=%h yv=%b busy=%b exp g0=%b g1=%b sel=%b y=%h yv=%b busy=%b",
                     k, $time, g0, g1, s, y, yv, busy, e_g0, e_g1, msel[k], my[k], myv[k], e_busy);
        end
    endtask

    always @(negedge clk) begin
        cmp_out(0, bus0.grant_0, bus0.grant_1, bus0.Select_out, bus0.Y_out, bus0.Y_valid, bus0.busy_out);
        cmp_out(1, bus1.grant_0, bus1.grant_1, bus1.Select_out, bus1.Y_out, bus1.Y_valid, bus1.busy_out);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0h exp %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic [7:0] a, input logic [7:0] b);
        bus0.req_0_in = r0; bus0.req_1_in = r1; bus0.A_in = a; bus0.B_in = b;
        bus1.req_0_in = r0; bus1.req_1_in = r1; bus1.A_in = a; bus1.B_in = b;
    endtask

    initial begin
        logic r0, r1;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        chk("rst_grant_0", bus0.grant_0, 0);
        chk("rst_grant_1", bus0.grant_1, 0);
        chk("rst_select", bus0.Select_out, 0);
        chk("rst_y", bus0.Y_out, 0);
        chk("rst_yvalid", bus0.Y_valid, 0);
        chk("rst_busy", bus0.busy_out, 0);

        // Both requesting from reset: port 0 first, bursts of 4 back to back.
        set_in(1'b1, 1'b1, 8'h11, 8'h22);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("tie_grant_0", bus0.grant_0, (i <= 4 || i == 9) ? 1 : 0);
            chk("tie_grant_1", bus0.grant_1, (i >= 5 && i <= 8) ? 1 : 0);
            chk("tie_select", bus0.Select_out, (i >= 5 && i <= 8) ? 1 : 0);
            chk("alt_grant_0", bus1.grant_0, i % 2);
            chk("alt_select", bus1.Select_out, (i % 2 == 0) ? 1 : 0);
            if (i >= 2) begin
                chk("tie_y", bus0.Y_out, (i <= 5) ? 8'h11 : 8'h22);
                chk("tie_yvalid", bus0.Y_valid, 1);
                chk("alt_y", bus1.Y_out, (i % 2 == 0) ? 8'h11 : 8'h22);
            end
        end
        repeat (6) @(negedge clk);
        chk("burst3_grant_1", bus0.grant_1, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_grant_1", bus0.grant_1, 0);
        chk("arst_yvalid", bus0.Y_valid, 0);
        chk("arst_select", bus0.Select_out, 0);
        chk("arst_busy", bus0.busy_out, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_grant_0", bus0.grant_0, 1);
        chk("post_rst_grant_1", bus0.grant_1, 0);
        chk("post_rst_yvalid", bus0.Y_valid, 0);

        set_in(1'b0, 1'b0, 8'h11, 8'h22);
        repeat (3) @(negedge clk);

        // Single requester held: continuous grant through burst-cap re-grants.
        set_in(1'b1, 1'b0, 8'hA5, 8'h5A);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("solo_grant_0", bus0.grant_0, 1);
            chk("solo_yvalid", bus0.Y_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) chk("solo_y", bus0.Y_out, 8'hA5);
        end
        set_in(1'b0, 1'b0, 8'hA5, 8'h5A);
        @(negedge clk);
        chk("drop_grant_0", bus0.grant_0, 0);
        chk("drop_yvalid", bus0.Y_valid, 0);
        chk("drop_y_hold", bus0.Y_out, 8'hA5);

        // One-cycle pulse on req_1: one grant cycle, no beat since the request is gone.
        @(negedge clk);
        set_in(1'b0, 1'b1, 8'hA5, 8'h3C);
        @(negedge clk);
        chk("pulse_grant_1", bus0.grant_1, 1);
        chk("pulse_select", bus0.Select_out, 1);
        set_in(1'b0, 1'b0, 8'hA5, 8'h3C);
        @(negedge clk);
        chk("pulse_end_grant_1", bus0.grant_1, 0);
        chk("pulse_no_beat", bus0.Y_valid, 0);
        chk("pulse_y_hold", bus0.Y_out, 8'hA5);
        chk("pulse_select_hold", bus0.Select_out, 1);
        chk("pulse_busy", bus0.busy_out, 0);

        // Randomized traffic with occasional asynchronous resets.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            set_in(r0, r1, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
